// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch tick counter and the FND display formatter:
// FSM state encoding, default moduli and output field widths.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam int MS_PER_CS_DEF = 10;
  localparam int CS_MAX_DEF    = 100;
  localparam int SEC_MAX_DEF   = 60;
  localparam int MIN_MAX_DEF   = 60;
  localparam int HOUR_MAX_DEF  = 24;

  // Field widths are fixed so the display formatter sees a stable interface.
  localparam int CS_W   = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

endpackage

// File: rtl/tick_counter_mod.sv
// Modulo-N counter with increment, synchronous clear and a combinational carry
// that is high in the cycle the count wraps from N-1 to 0.
module tick_counter_mod #(
  parameter int N = 10,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         carry
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign carry = inc && (count == LAST);

  // NOTE: clear outranks inc, so a CLEAR cycle can never leave a stray count behind.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (carry) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_tick_counter.sv
// Stopwatch driven by the 1 kHz divided clock: edge-detects it into 1 ms ticks and
// advances a cs/sec/min/hour cascade under a STOP/RUN/CLEAR control FSM.
module stopwatch_tick_counter
  import stopwatch_pkg::*;
#(
  parameter int MS_PER_CS = MS_PER_CS_DEF,
  parameter int CS_MAX    = CS_MAX_DEF,
  parameter int SEC_MAX   = SEC_MAX_DEF,
  parameter int MIN_MAX   = MIN_MAX_DEF,
  parameter int HOUR_MAX  = HOUR_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clk_1k,
  input  logic              i_run_stop,
  input  logic              i_clear,
  output logic [CS_W-1:0]   o_cs,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_running,
  output logic              o_cs_tick
);

  localparam int PRE_W = (MS_PER_CS > 1) ? $clog2(MS_PER_CS) : 1;

  state_t state, state_next;
  logic   clk_1k_prev;
  logic   tick_1ms;
  logic   count_en;
  logic   clr;
  logic   pre_carry, cs_carry, sec_carry, min_carry;

  // The prescaler value and the day rollover have no consumer outside this block.
  logic [PRE_W-1:0] unused_pre_count;
  logic             unused_day_wrap;

  assign tick_1ms = i_clk_1k && !clk_1k_prev;
  assign count_en = (state == ST_RUN) && tick_1ms;
  assign clr      = (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_1k_prev <= 1'b0;
      state       <= ST_STOP;
      o_running   <= 1'b0;
      o_cs_tick   <= 1'b0;
    end else begin
      clk_1k_prev <= i_clk_1k;
      state       <= state_next;
      o_running   <= (state_next == ST_RUN);
      o_cs_tick   <= pre_carry;
    end
  end

  // NOTE: next state defaults to the current state first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_STOP: begin
        if (i_clear)         state_next = ST_CLEAR;
        else if (i_run_stop) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_run_stop) state_next = ST_STOP;
      end
      ST_CLEAR: state_next = ST_STOP;
      default:  state_next = ST_STOP;
    endcase
  end

  // Prescaler keeps its partial centisecond across STOP; only CLEAR or reset drop it.
  tick_counter_mod #(.N(MS_PER_CS), .W(PRE_W)) u_pre (
    .clk(clk), .rst(rst), .inc(count_en), .clear(clr),
    .count(unused_pre_count), .carry(pre_carry)
  );

  tick_counter_mod #(.N(CS_MAX), .W(CS_W)) u_cs (
    .clk(clk), .rst(rst), .inc(pre_carry), .clear(clr),
    .count(o_cs), .carry(cs_carry)
  );

  tick_counter_mod #(.N(SEC_MAX), .W(SEC_W)) u_sec (
    .clk(clk), .rst(rst), .inc(cs_carry), .clear(clr),
    .count(o_sec), .carry(sec_carry)
  );

  tick_counter_mod #(.N(MIN_MAX), .W(MIN_W)) u_min (
    .clk(clk), .rst(rst), .inc(sec_carry), .clear(clr),
    .count(o_min), .carry(min_carry)
  );

  tick_counter_mod #(.N(HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk(clk), .rst(rst), .inc(min_carry), .clear(clr),
    .count(o_hour), .carry(unused_day_wrap)
  );

endmodule

// File: tb/tb_stopwatch_tick_counter.sv
// Self-checking bench: directed steps plus a random operation phase, compared against
// a model that tracks elapsed milliseconds and derives the time fields arithmetically.
module tb_stopwatch_tick_counter;
  import stopwatch_pkg::*;

  localparam int MS   = 2;
  localparam int CSM  = 100;
  localparam int SECM = 4;
  localparam int MINM = 2;
  localparam int HRM  = 2;
  localparam int FULL_MS = MS * CSM * SECM * MINM * HRM;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_clk_1k = 1'b0;
  logic              i_run_stop = 1'b0;
  logic              i_clear = 1'b0;
  logic [CS_W-1:0]   o_cs;
  logic [SEC_W-1:0]  o_sec;
  logic [MIN_W-1:0]  o_min;
  logic [HOUR_W-1:0] o_hour;
  logic              o_running;
  logic              o_cs_tick;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: elapsed milliseconds while running, plus run flag.
  int total_ms = 0;
  bit m_run    = 1'b0;

  int              tick_cnt  = 0;
  int              width_err = 0;
  int              align_err = 0;
  bit              mon_on    = 1'b0;
  logic            last_tick = 1'b0;
  logic [CS_W-1:0] last_cs   = '0;

  stopwatch_tick_counter #(
    .MS_PER_CS(MS), .CS_MAX(CSM), .SEC_MAX(SECM), .MIN_MAX(MINM), .HOUR_MAX(HRM)
  ) u_dut (
    .clk(clk), .rst(rst), .i_clk_1k(i_clk_1k), .i_run_stop(i_run_stop),
    .i_clear(i_clear), .o_cs(o_cs), .o_sec(o_sec), .o_min(o_min),
    .o_hour(o_hour), .o_running(o_running), .o_cs_tick(o_cs_tick)
  );

  always #5 clk = ~clk;

  function automatic int e_cs();   return (total_ms / MS) % CSM;                       endfunction
  function automatic int e_sec();  return (total_ms / (MS * CSM)) % SECM;              endfunction
  function automatic int e_min();  return (total_ms / (MS * CSM * SECM)) % MINM;       endfunction
  function automatic int e_hour(); return (total_ms / (MS * CSM * SECM * MINM)) % HRM; endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_cs"},   32'(o_cs),   32'(e_cs()));
    check({tag, "_sec"},  32'(o_sec),  32'(e_sec()));
    check({tag, "_min"},  32'(o_min),  32'(e_min()));
    check({tag, "_hour"}, 32'(o_hour), 32'(e_hour()));
    check({tag, "_run"},  32'(o_running), 32'(m_run));
  endtask

  // One clock: sample 1 ns after the edge and watch o_cs_tick width and alignment.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (mon_on) begin
      if (o_cs_tick && last_tick) width_err++;
      if (o_cs_tick !== (o_cs != last_cs)) align_err++;
    end
    if (o_cs_tick) tick_cnt++;
    last_tick = o_cs_tick;
    last_cs   = o_cs;
  endtask

  task automatic pulse_1k(input int n);
    mon_on = 1'b1;
    repeat (n) begin
      i_clk_1k = 1'b1;
      if (m_run) total_ms++;
      repeat (4) cyc();
      i_clk_1k = 1'b0;
      repeat (4) cyc();
    end
    mon_on = 1'b0;
  endtask

  task automatic run_stop();
    i_run_stop = 1'b1;
    cyc();
    i_run_stop = 1'b0;
    m_run = !m_run;
  endtask

  task automatic clear();
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    cyc();
    if (!m_run) total_ms = 0;
  endtask

  initial begin
    // 1. Reset with the 1 kHz input toggling.
    repeat (2) begin
      i_clk_1k = ~i_clk_1k;
      cyc();
    end
    check_all("rst_hold");
    check("rst_hold_tick", 32'(o_cs_tick), 32'd0);
    rst = 1'b0;
    cyc();
    check_all("rst_rel");
    check("rst_rel_tick", 32'(o_cs_tick), 32'd0);

    // 2. Counting from zero.
    run_stop();
    check_all("run_start");
    tick_cnt = 0;
    pulse_1k(20);
    check_all("count20");
    check("count20_ticks", 32'(tick_cnt), 32'd10);

    // 3. Pause keeps the partial centisecond.
    run_stop();
    clear();
    check_all("clr_stop");
    run_stop();
    pulse_1k(3);
    check_all("three_edges");
    run_stop();
    pulse_1k(5);
    check_all("paused");
    run_stop();
    pulse_1k(1);
    check_all("resumed");

    // 4. Clear priority over run_stop, run_stop ignored during CLEAR, clear ignored in RUN.
    pulse_1k(10);
    run_stop();
    check_all("at_cs7");
    i_clear    = 1'b1;
    i_run_stop = 1'b1;
    cyc();
    i_clear = 1'b0;
    check("clr_state_cs",  32'(o_cs), 32'd7);
    check("clr_state_run", 32'(o_running), 32'd0);
    cyc();
    i_run_stop = 1'b0;
    total_ms = 0;
    check_all("clr_done");
    cyc();
    check("clr_after_run", 32'(o_running), 32'd0);
    run_stop();
    pulse_1k(4);
    clear();
    check_all("clr_in_run");

    // 5. Tick coincident with run_stop: counted in RUN, not counted in STOP.
    i_clk_1k   = 1'b1;
    i_run_stop = 1'b1;
    total_ms++;
    m_run = 1'b0;
    cyc();
    i_run_stop = 1'b0;
    repeat (3) cyc();
    i_clk_1k = 1'b0;
    repeat (4) cyc();
    check_all("coinc_run");
    i_clk_1k   = 1'b1;
    i_run_stop = 1'b1;
    m_run = 1'b1;
    cyc();
    i_run_stop = 1'b0;
    repeat (3) cyc();
    i_clk_1k = 1'b0;
    repeat (4) cyc();
    check_all("coinc_stop");
    pulse_1k(1);
    check_all("coinc_after");

    // 6. Full rollover: all carries land on the same clock edge.
    run_stop();
    clear();
    run_stop();
    pulse_1k(FULL_MS - 2);
    check_all("pre_roll");
    pulse_1k(1);
    check_all("max_time");
    check("max_cs",   32'(o_cs),   32'(CSM - 1));
    check("max_hour", 32'(o_hour), 32'(HRM - 1));
    tick_cnt = 0;
    i_clk_1k = 1'b1;
    total_ms++;
    cyc();
    check_all("rollover");
    check("rollover_tick", 32'(tick_cnt), 32'd1);
    repeat (3) cyc();
    i_clk_1k = 1'b0;
    repeat (4) cyc();

    // 7. Reset mid-RUN at o_sec = 3, coincident with a tick.
    pulse_1k(MS * CSM * 3 + int'($urandom_range(0, 40)));
    check_all("sec3");
    check("sec3_val", 32'(o_sec), 32'd3);
    rst      = 1'b1;
    i_clk_1k = 1'b1;
    cyc();
    rst = 1'b0;
    total_ms = 0;
    m_run    = 1'b0;
    check_all("rst_mid");
    check("rst_mid_tick", 32'(o_cs_tick), 32'd0);
    repeat (3) cyc();
    i_clk_1k = 1'b0;
    repeat (4) cyc();
    pulse_1k(5);
    check_all("rst_stopped");
    run_stop();
    pulse_1k(4);
    check_all("rst_rerun");

    // 8. Random operation sequence.
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0, 1: pulse_1k(int'($urandom_range(1, 40)));
        2:    run_stop();
        default: clear();
      endcase
      check_all($sformatf("rand%0d", i));
    end

    check("tick_width_errs", 32'(width_err), 32'd0);
    check("tick_align_errs", 32'(align_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_tick_counter.md
Name: stopwatch_tick_counter

Overview:
- Consumer end of the 1 kHz divided-clock interface.
- Takes the slow square wave from the clock divider, which is generated in the same `clk` domain, and edge-detects it into single-cycle 1 ms ticks.
- Uses those ticks to advance a centisecond/second/minute/hour stopwatch under a run/stop/clear FSM.
- Outputs feed the FND display formatter.

Parameters:
- MS_PER_CS, default 10: number of 1 ms ticks per centisecond.
- CS_MAX, default 100: centisecond modulus.
- SEC_MAX, default 60: second modulus.
- MIN_MAX, default 60: minute modulus.
- HOUR_MAX, default 24: hour modulus.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- i_clk_1k  in  1  divided square wave from the divider (1 kHz, clk-synchronous).
- i_run_stop  in  1  single-cycle pulse; toggles between RUN and STOP.
- i_clear  in  1  single-cycle pulse; zeroes time, honoured only in STOP.
- o_cs  out  7  centiseconds, 0..CS_MAX-1.
- o_sec  out  6  seconds, 0..SEC_MAX-1.
- o_min  out  6  minutes, 0..MIN_MAX-1.
- o_hour  out  5  hours, 0..HOUR_MAX-1.
- o_running  out  1  high while in RUN.
- o_cs_tick  out  1  one-cycle pulse, registered, in the cycle o_cs changes.

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - All count outputs = 0, o_running = 0, o_cs_tick = 0.
  - State = STOP, prescaler = 0, edge register = 0.
  - Reset overrides every other input in that cycle, including mid-RUN.
- Edge detect:
  - prev <= i_clk_1k each cycle.
  - tick_1ms = i_clk_1k & ~prev (rising edge only).
  - The first rising edge after reset produces a tick.
  - Falling edges are ignored.
- FSM states are STOP, RUN, CLEAR.
  - STOP: i_clear -> CLEAR. Otherwise i_run_stop -> RUN. If both pulse in the same cycle, clear wins.
  - RUN: i_run_stop -> STOP. i_clear is ignored.
  - CLEAR: lasts exactly one cycle. Zeroes prescaler and all counters, then unconditionally -> STOP. Inputs arriving in that cycle are ignored.
- o_running is registered and equals (next state == RUN), so it rises the cycle after the accepted i_run_stop.
- Prescaler:
  - Advances only when state == RUN and tick_1ms.
  - At MS_PER_CS-1 it wraps to 0 and generates cs_inc.
  - It holds its value across STOP, so pausing does not lose a partial centisecond.
- Cascade (all updates in the same clock edge as cs_inc):
  - cs_inc: o_cs +1; at CS_MAX-1 wraps to 0 and carries to o_sec.
  - o_sec wraps at SEC_MAX-1 and carries to o_min.
  - o_min wraps at MIN_MAX-1 and carries to o_hour.
  - o_hour wraps at HOUR_MAX-1 to 0 (full rollover 23:59:59.99 -> 00:00:00.00).
- Latency: the prescaler and counters update at the clk edge following the cycle where tick_1ms is high. o_cs_tick is high in the same cycle the new o_cs value first appears.
- Tick coincident with i_run_stop in RUN: the tick is still counted (state is RUN in that cycle); counting stops from the next cycle.
- Tick coincident with i_run_stop in STOP: not counted.
- Widths: each counter is sized for its modulus; comparisons are against MAX-1; no arithmetic overflow beyond the wrap.

Decomposition:
- Shared package `stopwatch_pkg` holds:
  - state encoding localparams: ST_STOP=2'd0, ST_RUN=2'd1, ST_CLEAR=2'd2;
  - default moduli;
  - the output field widths (7/6/6/5), which the display formatter also uses.
- One natural sub-module, `tick_counter_mod`: a parameterised modulo-N counter with inc/clear inputs and a carry output. It is instantiated four times in a chain; the prescaler is a fifth instance with N=MS_PER_CS.
- FSM and edge detect stay in the top level.

Test Plan (sim parameters MS_PER_CS=2; i_clk_1k driven as a square wave with period 8 clk):
1. Reset check: assert rst 2 cycles with i_clk_1k toggling -> all outputs 0, o_running 0, no o_cs_tick.
2. Counting from zero: run_stop pulse, then 20 rising edges of i_clk_1k -> o_cs=10, o_sec=0, o_running=1. Exactly 10 o_cs_tick pulses; each is 1 cycle wide and follows every 2nd edge.
3. Pause keeps the partial centisecond: in RUN after 3 edges (o_cs=1, prescaler=1), pulse run_stop, apply 5 more edges -> o_cs stays 1. Pulse run_stop again and apply 1 edge -> o_cs=2.
4. Clear priority and rejection: in STOP with o_cs=7, pulse i_clear and i_run_stop in the same cycle -> next cycle state CLEAR, then STOP; all counts 0; o_running stays 0. In RUN, an i_clear pulse leaves counts unchanged.
5. Full rollover: force state to 23:59:59.99 (via hierarchical preload or long run with small moduli) plus 2 edges -> 00:00:00.00. Carries to sec, min and hour occur in the same clk edge.
6. Reset mid-RUN: at o_sec=3, assert rst for 1 cycle coincident with a tick -> all zero, STOP. Subsequent ticks do not count until run_stop.
